// File: rtl/tcs3200_color_classifier.sv
// TCS3200 colour classifier: cycles the filter select through R/G/B/C, counts OUT pulses per gate window,
// and publishes a one-hot colour per round. Define COLOR_STABLE_EN to require STABLE_COUNT matching rounds.
module tcs3200_color_classifier #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16,
    parameter int MIN_CLEAR     = 100,
    parameter int MARGIN        = 8,
    parameter int STABLE_COUNT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sensor_out,
    output logic [1:0] s2s3,
    output logic [2:0] color,
    output logic       color_valid,
    output logic       busy
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_CLEAR_C = CNT_W'(MIN_CLEAR);
    localparam logic [CNT_W-1:0] MARGIN_C    = CNT_W'(MARGIN);

    typedef enum logic [3:0] {
        IDLE, SET_R, GATE_R, SET_G, GATE_G, SET_B, GATE_B, SET_C, GATE_C, CLASSIFY
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             sync_p0, sync_p1, sync_p2;
    logic             rise;
    logic             is_set, is_gate, last_set, last_gate, fire;
    logic [CNT_W-1:0] edge_cnt, gate_val;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, cnt_c;
    logic [2:0]       raw_color;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Exact ties fall out as "ambiguous" because top - second is then 0 < MARGIN.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b, input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] top, second;
        logic [2:0]       hot;
        if (r >= g && r >= b) begin
            top = r; second = (g >= b) ? g : b; hot = 3'b001;
        end else if (g >= b) begin
            top = g; second = (r >= b) ? r : b; hot = 3'b010;
        end else begin
            top = b; second = (r >= g) ? r : g; hot = 3'b100;
        end
        if (c < MIN_CLEAR_C || (top - second) < MARGIN_C)
            classify = 3'b000;
        else
            classify = hot;
    endfunction

    // Stage p0/p1: metastability synchronizer; p2: previous sample for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= sensor_out;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise      = sync_p1 & ~sync_p2;
    assign is_set    = (state == SET_R) || (state == SET_G) || (state == SET_B) || (state == SET_C);
    assign is_gate   = (state == GATE_R) || (state == GATE_G) || (state == GATE_B) || (state == GATE_C);
    assign last_set  = is_set && (tmr == SETTLE_LAST);
    assign last_gate = is_gate && (tmr == GATE_LAST);
    assign fire      = (state == CLASSIFY) && enable;
    assign gate_val  = rise ? sat_inc(edge_cnt) : edge_cnt;
    assign raw_color = classify(cnt_r, cnt_g, cnt_b, cnt_c);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s2s3      = 2'b00;
        busy      = (state != IDLE);
        case (state)
            SET_G, GATE_G:          s2s3 = 2'b11;
            SET_B, GATE_B:          s2s3 = 2'b01;
            SET_C, GATE_C, CLASSIFY: s2s3 = 2'b10;
            default:                s2s3 = 2'b00;
        endcase
        if (state != IDLE && !enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (enable)    state_nxt = SET_R;
                SET_R:    if (last_set)  state_nxt = GATE_R;
                GATE_R:   if (last_gate) state_nxt = SET_G;
                SET_G:    if (last_set)  state_nxt = GATE_G;
                GATE_G:   if (last_gate) state_nxt = SET_B;
                SET_B:    if (last_set)  state_nxt = GATE_B;
                GATE_B:   if (last_gate) state_nxt = SET_C;
                SET_C:    if (last_set)  state_nxt = GATE_C;
                GATE_C:   if (last_gate) state_nxt = CLASSIFY;
                CLASSIFY: state_nxt = SET_R;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmr <= '0;
        else if (state_nxt != state || state == IDLE)
            tmr <= '0;
        else
            tmr <= tmr + TMR_W'(1);
    end

    // The final gate cycle's edge is folded into the stored count, then the counter restarts from 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= '0;
            cnt_r    <= '0;
            cnt_g    <= '0;
            cnt_b    <= '0;
            cnt_c    <= '0;
        end else begin
            edge_cnt <= (is_gate && !last_gate && enable) ? gate_val : '0;
            if (last_gate && enable) begin
                case (state)
                    GATE_R:  cnt_r <= gate_val;
                    GATE_G:  cnt_g <= gate_val;
                    GATE_B:  cnt_b <= gate_val;
                    default: cnt_c <= gate_val;
                endcase
            end
        end
    end

`ifdef COLOR_STABLE_EN
    localparam int RUN_W = $clog2(STABLE_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);

    logic [2:0]       prev_raw;
    logic [RUN_W-1:0] run_cnt, run_nxt;

    // A zero run count means no history, so the first round always starts a run of one.
    always_comb begin
        run_nxt = RUN_W'(1);
        if (run_cnt != '0 && raw_color == prev_raw)
            run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_raw <= 3'b000;
            run_cnt  <= '0;
        end else if (!enable) begin
            prev_raw <= 3'b000;
            run_cnt  <= '0;
        end else if (fire) begin
            prev_raw <= raw_color;
            run_cnt  <= run_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color       <= 3'b000;
            color_valid <= 1'b0;
        end else begin
            color_valid <= fire;
            if (fire && run_nxt == RUN_MAX)
                color <= raw_color;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color       <= 3'b000;
            color_valid <= 1'b0;
        end else begin
            color_valid <= fire;
            if (fire)
                color <= raw_color;
        end
    end
`endif

endmodule

// File: tb/tb_tcs3200_color_classifier.sv
// Bench for tcs3200_color_classifier: a period-per-filter sensor model drives two instances (16-bit and
// 4-bit counters); expected colours come from nominal pulse counts with +/-1 tolerance per channel.
module tb_tcs3200_color_classifier;

    localparam int GATE_NS = 1000;   // 100 gate cycles of a 10-unit clock
    localparam int LAT     = 441;

    logic       clk, reset;
    logic       enable_a, sensor_a, color_valid_a, busy_a;
    logic [1:0] s2s3_a;
    logic [2:0] color_a;
    logic       enable_b, sensor_b, color_valid_b, busy_b;
    logic [1:0] s2s3_b;
    logic [2:0] color_b;

    int per_a[4] = '{100, 100, 100, 100};   // periods indexed red, green, blue, clear
    int per_b[4] = '{100, 100, 100, 100};
    int total = 0;
    int bad   = 0;
    logic [1:0] seq[4];
    logic [2:0] col_m[2];
`ifdef COLOR_STABLE_EN
    logic [2:0] hist_a[$];
    logic [2:0] hist_b[$];
`endif

    tcs3200_color_classifier #(
        .GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(16), .MIN_CLEAR(20), .MARGIN(5), .STABLE_COUNT(3)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a), .sensor_out(sensor_a),
        .s2s3(s2s3_a), .color(color_a), .color_valid(color_valid_a), .busy(busy_a)
    );

    tcs3200_color_classifier #(
        .GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(4), .MIN_CLEAR(10), .MARGIN(5), .STABLE_COUNT(3)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .sensor_out(sensor_b),
        .s2s3(s2s3_b), .color(color_b), .color_valid(color_valid_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int chan(input logic [1:0] sel);
        case (sel)
            2'b00:   return 0;
            2'b11:   return 1;
            2'b01:   return 2;
            default: return 3;
        endcase
    endfunction

    // Sensor model: square wave restarting its phase whenever the filter select changes.
    initial begin
        logic [1:0] sel_a, sel_b;
        int ph_a, ph_b, p;
        sel_a = 2'b00; sel_b = 2'b00; ph_a = 0; ph_b = 0;
        sensor_a = 1'b0; sensor_b = 1'b0;
        forever begin
            #1;
            if (s2s3_a !== sel_a) begin sel_a = s2s3_a; ph_a = 0; end
            p = per_a[chan(sel_a)];
            sensor_a = (ph_a < p / 2);
            ph_a = (ph_a + 1 >= p) ? 0 : ph_a + 1;
            if (s2s3_b !== sel_b) begin sel_b = s2s3_b; ph_b = 0; end
            p = per_b[chan(sel_b)];
            sensor_b = (ph_b < p / 2);
            ph_b = (ph_b + 1 >= p) ? 0 : ph_b + 1;
        end
    end

    function automatic logic [2:0] class4(input int v[4], input int minc, input int marg);
        int k, second;
        k = 0;
        if (v[1] > v[k]) k = 1;
        if (v[2] > v[k]) k = 2;
        second = -1;
        for (int j = 0; j < 3; j++)
            if (j != k && v[j] > second) second = v[j];
        if (v[3] < minc || v[k] - second < marg) return 3'b000;
        return 3'b001 << k;
    endfunction

    // Returns 3'b111 when the +/-1 count tolerance could change the outcome.
    function automatic logic [2:0] exp_raw(input int p[4], input int cntw, input int minc, input int marg);
        int maxv, t;
        int n[4], v[4];
        logic [2:0] first, cur;
        maxv = (1 << cntw) - 1;
        first = 3'b000;
        for (int i = 0; i < 4; i++) n[i] = (GATE_NS / p[i] > maxv) ? maxv : GATE_NS / p[i];
        for (int k = 0; k < 81; k++) begin
            t = k;
            for (int i = 0; i < 4; i++) begin
                v[i] = n[i] + (t % 3) - 1;
                t = t / 3;
                if (v[i] < 0) v[i] = 0;
                if (v[i] > maxv) v[i] = maxv;
            end
            cur = class4(v, minc, marg);
            if (k == 0) first = cur;
            else if (cur != first) return 3'b111;
        end
        return first;
    endfunction

    task automatic publish(input int inst, input logic [2:0] raw);
`ifdef COLOR_STABLE_EN
        logic same;
        if (inst == 0) hist_a.push_back(raw); else hist_b.push_back(raw);
        same = 1'b0;
        if (inst == 0 && hist_a.size() >= 3)
            same = (hist_a[$] == hist_a[$-1]) && (hist_a[$-1] == hist_a[$-2]);
        if (inst == 1 && hist_b.size() >= 3)
            same = (hist_b[$] == hist_b[$-1]) && (hist_b[$-1] == hist_b[$-2]);
        if (same) col_m[inst] = raw;
`else
        col_m[inst] = raw;
`endif
    endtask

    task automatic clear_hist();
`ifdef COLOR_STABLE_EN
        hist_a.delete();
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered on SET_R cycle 0; returns on the strobe cycle, which is SET_R cycle 0 of the next round.
    task automatic run_round(input int inst, output int lat);
        lat = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (inst == 0 && cyc % 110 == 0 && cyc < 440) seq[cyc / 110] = s2s3_a;
            if (cyc > 0 && (inst == 0 ? color_valid_a : color_valid_b) === 1'b1) begin
                lat = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic round_a(input string tag, input int p0, input int p1, input int p2, input int p3);
        int lat;
        logic [2:0] raw;
        per_a = '{p0, p1, p2, p3};
        raw = exp_raw(per_a, 16, 20, 5);
        run_round(0, lat);
        chk({tag, "_lat"}, lat, LAT);
        publish(0, raw);
        chk({tag, "_color"}, color_a, col_m[0]);
    endtask

    initial begin
        int lat, seen, tries;
        logic [2:0] raw;
        col_m[0] = 3'b000; col_m[1] = 3'b000;
        reset = 1'b1; enable_a = 1'b0; enable_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s2s3", s2s3_a, 2'b00);
        chk("rst_color", color_a, 3'b000);
        chk("rst_valid", color_valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        reset = 1'b0;

        // Saturating 4-bit counters: R and C both pin at 15, G/B around 2.
        per_b = '{40, 400, 400, 22};
        raw = exp_raw(per_b, 4, 10, 5);
        enable_b = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            run_round(1, lat);
            chk("sat_lat", lat, LAT);
            publish(1, raw);
            chk("sat_color", color_b, col_m[1]);
        end
        enable_b = 1'b0;
        @(negedge clk);

        // Red object, first round from IDLE
        enable_a = 1'b1;
        @(negedge clk);
        chk("start_busy", busy_a, 1'b1);
        round_a("red", 40, 100, 100, 22);
        chk("seq_r", seq[0], 2'b00);
        chk("seq_g", seq[1], 2'b11);
        chk("seq_b", seq[2], 2'b01);
        chk("seq_c", seq[3], 2'b10);

        round_a("none1", 200, 200, 200, 200);
        round_a("none2", 200, 200, 200, 200);
        round_a("ambig", 40, 43, 100, 22);
        round_a("blue", 40, 43, 25, 22);

        round_a("st_r1", 40, 100, 100, 22);
        round_a("st_r2", 40, 100, 100, 22);
        round_a("st_g", 100, 40, 100, 22);
        round_a("st_r3", 40, 100, 100, 22);
        round_a("st_r4", 40, 100, 100, 22);
        round_a("st_r5", 40, 100, 100, 22);

        for (int r = 0; r < 6; r++) begin
            int p[4];
            tries = 0;
            do begin
                for (int i = 0; i < 4; i++) p[i] = $urandom_range(22, 300);
                tries++;
            end while (exp_raw(p, 16, 20, 5) == 3'b111 && tries < 200);
            if (exp_raw(p, 16, 20, 5) == 3'b111) p = '{40, 100, 100, 22};
            round_a("rand", p[0], p[1], p[2], p[3]);
        end

        // Drop enable during GATE_G
        per_a = '{40, 100, 100, 22};
        repeat (150) @(negedge clk);
        enable_a = 1'b0;
        @(negedge clk);
        clear_hist();
        chk("drop_busy", busy_a, 1'b0);
        chk("drop_s2s3", s2s3_a, 2'b00);
        chk("drop_color", color_a, col_m[0]);
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            if (color_valid_a === 1'b1) seen++;
            @(negedge clk);
        end
        chk("drop_nostrobe", seen, 0);
        chk("drop_hold", color_a, col_m[0]);
        enable_a = 1'b1;
        @(negedge clk);
        round_a("reen", 40, 100, 100, 22);

        // Asynchronous reset during GATE_B
        repeat (250) @(negedge clk);
        reset = 1'b1;
        #1;
        clear_hist();
        col_m[0] = 3'b000;
        chk("arst_color", color_a, 3'b000);
        chk("arst_valid", color_valid_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_s2s3", s2s3_a, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        round_a("post_rst", 40, 100, 100, 22);
        enable_a = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
